// File: rtl/conv3x3_tap_scheduler.sv
// Tap sequencer for the shared 3x3 convolution MAC: clears, walks nine taps per filter,
// drains the MAC pipe and flags each result. Optional `STALL_CNT_EN adds a stall counter port.
module conv3x3_tap_scheduler #(
  parameter int FIDX_W  = 3,
  parameter int MAC_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [FIDX_W:0]   cfg_nf,
  input  logic              mac_ready,
  output logic              busy,
  output logic              done,
  output logic              mac_clr,
  output logic              mac_en,
  output logic [3:0]        tap_idx,
  output logic [FIDX_W-1:0] filt_idx,
  output logic              res_valid,
  output logic [FIDX_W-1:0] res_filt_idx,
`ifdef STALL_CNT_EN
  output logic [15:0]       stall_cnt,
`endif
  output logic [2:0]        dbg_state
);

  // Handshake: a tap transfers on every cycle where mac_en (state ACCUM) and mac_ready are both high;
  // mac_ready low in ACCUM holds the current tap, it is never dropped or reissued.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_ACCUM = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int            DW         = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(MAC_LAT - 1);

  state_t            state, state_n;
  logic [3:0]        tap_q, tap_n;
  logic [FIDX_W-1:0] filt_q, filt_n;
  logic [FIDX_W:0]   nf_q, nf_n;
  logic [DW-1:0]     drain_q, drain_n;
  logic [FIDX_W:0]   nf_last;

  // One bit wider than filt_idx so nf = 2^FIDX_W ends on the top index without wrapping.
  assign nf_last = nf_q - (FIDX_W+1)'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      tap_q   <= '0;
      filt_q  <= '0;
      nf_q    <= '0;
      drain_q <= '0;
    end else begin
      state   <= state_n;
      tap_q   <= tap_n;
      filt_q  <= filt_n;
      nf_q    <= nf_n;
      drain_q <= drain_n;
    end
  end

  always_comb begin
    state_n = state;
    tap_n   = tap_q;
    filt_n  = filt_q;
    nf_n    = nf_q;
    drain_n = drain_q;
    case (state)
      S_IDLE: begin
        if (start) begin
          nf_n   = cfg_nf;
          filt_n = '0;
          state_n = (cfg_nf == '0) ? S_DONE : S_CLEAR;
        end
      end
      S_CLEAR: begin
        tap_n   = 4'd0;
        drain_n = '0;
        state_n = S_ACCUM;
      end
      S_ACCUM: begin
        if (mac_ready) begin
          if (tap_q == 4'd8) state_n = S_DRAIN;
          else               tap_n   = tap_q + 4'd1;
        end
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          drain_n = '0;
          if ({1'b0, filt_q} == nf_last) begin
            state_n = S_DONE;
          end else begin
            filt_n  = filt_q + FIDX_W'(1);
            state_n = S_CLEAR;
          end
        end else begin
          drain_n = drain_q + DW'(1);
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  assign busy         = (state != S_IDLE);
  assign done         = (state == S_DONE);
  assign mac_clr      = (state == S_CLEAR);
  assign mac_en       = (state == S_ACCUM) & mac_ready;
  assign res_valid    = (state == S_DRAIN) && (drain_q == DRAIN_LAST);
  assign tap_idx      = tap_q;
  assign filt_idx     = filt_q;
  assign res_filt_idx = filt_q;
  assign dbg_state    = state;

`ifdef STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  stall_q <= '0;
    else if (state == S_IDLE && start)        stall_q <= '0;
    else if (state == S_ACCUM && !mac_ready && stall_q != 16'hFFFF)
                                              stall_q <= stall_q + 16'd1;
  end

  assign stall_cnt = stall_q;
`endif

endmodule
